// File: rtl/serial_sub.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin over WIDTH bits,
// one bit per clock through a single full-subtractor cell and a borrow register.
`timescale 1ns/1ps

module serial_sub #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-2:0] acc;
   logic             c;

   logic             x;
   logic             y;
   logic             d;
   logic             c_nxt;
   logic             last;
   logic [WIDTH-1:0] acc_shift;

   // Full-subtractor cell on the current LSBs of the operand shift registers.
   assign x         = sa[0];
   assign y         = sb[0];
   assign d         = x ^ y ^ c;
   assign c_nxt     = (~x & y) | (~x & c) | (y & c);
   assign last      = (cnt == CW'(WIDTH - 1));
   // Difference bits enter from the MSB side; the final shift lands bit 0 at position 0.
   assign acc_shift = {d, acc};

   always_ff @(posedge clk) begin
      // NOTE: sequential state is written only with <=, so every register sees pre-edge values.
      if (!rst_n) begin
         // NOTE: the operand shift registers are cleared too, keeping the whole block in a known state after abort.
         state <= IDLE;
         cnt   <= '0;
         sa    <= '0;
         sb    <= '0;
         acc   <= '0;
         c     <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         diff  <= '0;
         bout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  c     <= bin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               acc <= acc_shift[WIDTH-1:1];
               c   <= c_nxt;
               cnt <= cnt + 1'b1;
               if (last) begin
                  // c is the borrow into the MSB, c_nxt the borrow out of it.
                  diff  <= acc_shift;
                  bout  <= c_nxt;
                  ovf   <= c ^ c_nxt;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: scoreboard of expected results popped on
// each done pulse, plus directed checks of latency, handshake and reset abort.
`timescale 1ns/1ps

module tb_serial_sub;

   localparam int W = 4;

   typedef struct packed {
      logic [W-1:0] diff;
      logic         bout;
      logic         ovf;
   } res_t;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;

   res_t sbq[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   done_cnt = 0;

   serial_sub #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: unsigned borrow from a widened subtraction, overflow from signed range.
   function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
      logic [W:0] t;
      int         sa_i;
      int         sb_i;
      int         s;
      res_t       r;
      t    = {1'b1, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
      sa_i = ma[W-1] ? int'(ma) - (1 << W) : int'(ma);
      sb_i = mb[W-1] ? int'(mb) - (1 << W) : int'(mb);
      s    = sa_i - sb_i - int'(mbin);
      r.diff = t[W-1:0];
      r.bout = ~t[W];
      r.ovf  = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
      return r;
   endfunction

   // Scoreboard consumer: every done pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (rst_n && done) begin
         res_t e;
         done_cnt++;
         check("sb_not_empty", sbq.size() != 0, 1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("diff", diff, e.diff);
            check("bout", bout, e.bout);
            check("ovf", ovf, e.ovf);
         end
      end
   end

   task automatic start_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_bin);
      a     = op_a;
      b     = op_b;
      bin   = op_bin;
      start = 1'b1;
      sbq.push_back(model(op_a, op_b, op_bin));
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_bin);
      int lat;
      start_op(op_a, op_b, op_bin);
      check("busy_after_accept", busy, 1);
      lat = 0;
      while (lat < 4 * W) begin
         @(posedge clk);
         #1;
         lat++;
         if (done) break;
      end
      check("latency", lat, W);
      @(posedge clk);
      #1;
      check("done_one_cycle", done, 0);
      check("busy_release", busy, 0);
   endtask

   initial begin
      int   d0;
      int   lat;
      int   last_done;
      int   low_run;
      int   order[512];
      res_t hold_exp;

      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_diff", diff, 0);
      check("rst_bout", bout, 0);
      check("rst_ovf", ovf, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed operations, including borrow-out and both signed overflow directions.
      run_op(4'd9, 4'd3, 1'b0);
      check("held_diff_9_3", diff, 6);
      run_op(4'd3, 4'd5, 1'b0);
      run_op(4'd0, 4'd0, 1'b1);
      check("held_diff_0_0_1", diff, 4'hF);
      run_op(4'd8, 4'd1, 1'b0);
      check("held_ovf_8_1", ovf, 1);
      run_op(4'd7, 4'd8, 1'b0);
      check("held_ovf_7_8", ovf, 1);

      // Start pulse two clocks after acceptance must be ignored.
      d0 = done_cnt;
      start_op(4'd9, 4'd3, 1'b0);
      lat = 0;
      while (lat < 4 * W) begin
         if (lat == 1) begin
            a     = 4'd1;
            b     = 4'd1;
            bin   = 1'b1;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         check("busy_during_op", busy, 1);
         @(posedge clk);
         #1;
         lat++;
         if (done) break;
      end
      start = 1'b0;
      check("ignored_start_latency", lat, W);
      repeat (10) @(posedge clk);
      #1;
      check("ignored_start_done_count", done_cnt - d0, 1);
      check("ignored_start_busy_idle", busy, 0);
      check("ignored_start_queue", sbq.size(), 0);

      // Reset for one edge in the middle of RUN aborts and clears all outputs.
      start_op(4'd5, 4'd2, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sbq.delete();
      d0 = done_cnt;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_diff", diff, 0);
      check("abort_bout", bout, 0);
      check("abort_ovf", ovf, 0);
      repeat (6) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt - d0, 0);
      run_op(4'd9, 4'd3, 1'b0);
      check("after_abort_diff", diff, 6);

      // start held high: back-to-back operations every W+2 clocks.
      d0        = done_cnt;
      last_done = -1;
      low_run   = 0;
      a         = 4'd12;
      b         = 4'd5;
      bin       = 1'b1;
      hold_exp  = model(4'd12, 4'd5, 1'b1);
      start     = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i % (W + 2) == 0) sbq.push_back(hold_exp);
         @(posedge clk);
         #1;
         if (done) begin
            if (last_done >= 0) check("done_period", i - last_done, W + 2);
            last_done = i;
         end
         if (!busy) begin
            low_run++;
         end else begin
            if (low_run != 0) check("busy_gap", low_run, 1);
            low_run = 0;
         end
      end
      start = 1'b0;
      check("hold_done_count", done_cnt - d0, 3);
      repeat (10) @(posedge clk);
      #1;
      check("hold_total_done", done_cnt - d0, 4);
      check("hold_queue_drained", sbq.size(), 0);

      // Exhaustive sweep of (a, b, bin) in shuffled order.
      for (int i = 0; i < 512; i++) order[i] = i;
      for (int i = 511; i > 0; i--) begin
         int j;
         int t;
         j        = int'($urandom_range(i, 0));
         t        = order[i];
         order[i] = order[j];
         order[j] = t;
      end
      for (int i = 0; i < 512; i++) begin
         logic [8:0] v;
         v = 9'(order[i]);
         run_op(v[8:5], v[4:1], v[0]);
      end
      check("sweep_queue_drained", sbq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
